// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - digit write port bundle for display_scan_ctrl
//
// Signals:
//   wr_valid  write request from the writer
//   wr_ready  write accepted when wr_valid & wr_ready
//   wr_digit  target digit index (values >= NUM_DIGITS are accepted and dropped)
//   wr_value  hex nibble for the target digit
// Modports:
//   master  the writer (drives valid/digit/value, observes ready)
//   slave   display_scan_ctrl (observes valid/digit/value, drives ready)

interface display_scan_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_digit;
    logic [3:0] wr_value;

    modport master (
        output wr_valid,
        output wr_digit,
        output wr_value,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_digit,
        input  wr_value,
        output wr_ready
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - round-robin 7-segment scan scheduler with frame-atomic digit updates
//
// Parameters:
//   NUM_DIGITS    digits scanned (2..8)
//   DWELL_CYCLES  clk cycles each digit is driven (>= 1)
//   BLANK_CYCLES  clk cycles with all digits off between digits (>= 1)
// Ports:
//   clk         system clock
//   reset       synchronous, active-low
//   brightness  4-bit duty setting, present only with BRIGHTNESS_PWM_EN defined
//   wr          digit write port (display_scan_ctrl_if.slave)
//   digit_en    one-hot digit enable, active-high
//   nibble      value of the selected digit, to the seven-segment decoder
//   frame_tick  one-cycle pulse in the commit cycle
// Build option:
//   BRIGHTNESS_PWM_EN  when defined, gates digit_en during DRIVE with a
//                      free-running 4-bit PWM compared against brightness.

module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0]            brightness,
`endif
    display_scan_ctrl_if.slave    wr,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [3:0]            nibble,
    output logic                  frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [3:0]       NUM_DIGITS_W = 4'(NUM_DIGITS);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;

    logic [3:0]            committed [NUM_DIGITS];
    logic [3:0]            pending   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] pend_flag;

    logic                  blank_done;
    logic                  dwell_done;
    logic                  last_digit;
    logic                  commit_cycle;
    logic [IDX_W-1:0]      next_idx;
    logic [3:0]            next_nibble;
    logic                  wr_accept;
    logic                  wr_in_range;
    logic [IDX_W-1:0]      wr_slot;
    logic                  drive_on;

    assign blank_done   = (state == ST_BLANK) && (cnt == BLANK_LAST);
    assign dwell_done   = (state == ST_DRIVE) && (cnt == DWELL_LAST);
    assign last_digit   = (idx == LAST_IDX);
    assign commit_cycle = dwell_done && last_digit;
    assign next_idx     = last_digit ? '0 : idx + 1'b1;

    // In the commit cycle the only digit loaded next is 0, and it must see
    // the value being committed on this same edge, so bypass the pending
    // register when its flag is set.
    assign next_nibble = (commit_cycle && pend_flag[next_idx]) ? pending[next_idx]
                                                               : committed[next_idx];

    // Holding off writes in the commit cycle keeps a write from landing
    // half-in/half-out of a frame; the writer simply retries next cycle.
    assign wr.wr_ready  = reset & ~commit_cycle;
    assign wr_accept    = wr.wr_valid & wr.wr_ready;
    assign wr_in_range  = ({1'b0, wr.wr_digit} < NUM_DIGITS_W);
    assign wr_slot      = wr.wr_digit[IDX_W-1:0];

    assign frame_tick   = commit_cycle;

    // Scan sequencer: BLANK then DRIVE per digit, nibble preloaded on the
    // DRIVE->BLANK edge so it is stable before the next digit lights.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_BLANK;
            idx    <= '0;
            cnt    <= '0;
            nibble <= 4'd0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (blank_done) begin
                        cnt   <= '0;
                        state <= ST_DRIVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (dwell_done) begin
                        cnt    <= '0;
                        state  <= ST_BLANK;
                        idx    <= next_idx;
                        nibble <= next_nibble;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Double-buffered digit store. Commit and accept are mutually exclusive
    // because wr_ready is low in the commit cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                committed[i] <= 4'd0;
                pending[i]   <= 4'd0;
            end
            pend_flag <= '0;
        end else if (commit_cycle) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (pend_flag[i]) begin
                    committed[i] <= pending[i];
                end
            end
            pend_flag <= '0;
        end else if (wr_accept && wr_in_range) begin
            pending[wr_slot]   <= wr.wr_value;
            pend_flag[wr_slot] <= 1'b1;
        end
    end

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign drive_on = (pwm_cnt <= brightness);
`else
    assign drive_on = 1'b1;
`endif

    always_comb begin
        digit_en = '0;
        if (state == ST_DRIVE && drive_on) begin
            digit_en = NUM_DIGITS'(1) << idx;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl

module tb_display_scan_ctrl;

    localparam int ND = 2;
    localparam int DW = 8;
    localparam int BL = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] digit_en;
    logic [3:0] nibble;
    logic       frame_tick;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] brightness = 4'd15;
`endif

    int total = 0;
    int bad   = 0;

    display_scan_ctrl_if wr_if ();

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef BRIGHTNESS_PWM_EN
        .brightness (brightness),
`endif
        .wr         (wr_if),
        .digit_en   (digit_en),
        .nibble     (nibble),
        .frame_tick (frame_tick)
    );

    // Hand-derived scan waveform for DW=8, BL=2: period 20 cycles.
    function automatic logic [1:0] exp_en(input int k);
        int m;
        m = k % 20;
        if (m < 2)  return 2'b00;
        if (m < 10) return 2'b01;
        if (m < 12) return 2'b00;
        return 2'b10;
    endfunction

    task automatic idle_wr();
        wr_if.wr_valid = 1'b0;
        wr_if.wr_digit = 3'd0;
        wr_if.wr_value = 4'd0;
    endtask

    task automatic put_wr(input logic [2:0] d, input logic [3:0] v);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_digit = d;
        wr_if.wr_value = v;
    endtask

    // Leaves the bench at the negedge preceding edge 0 with reset released.
    task automatic start();
        reset = 1'b0;
        idle_wr();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_wr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (digit_en !== 2'b00) begin bad++; $display("FAIL reset_digit_en got=%b exp=00", digit_en); end
        total++; if (nibble !== 4'h0) begin bad++; $display("FAIL reset_nibble got=%h exp=0", nibble); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
        total++; if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%b exp=0", wr_if.wr_ready); end
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #1;
            total++;
            if (digit_en !== exp_en(k)) begin
                bad++; $display("FAIL scan_digit_en cyc=%0d got=%b exp=%b", k, digit_en, exp_en(k));
            end
            total++;
            if (frame_tick !== ((k % 20) == 19)) begin
                bad++; $display("FAIL scan_frame_tick cyc=%0d got=%b exp=%b", k, frame_tick, (k % 20) == 19);
            end
            total++;
            if (wr_if.wr_ready !== ((k % 20) != 19)) begin
                bad++; $display("FAIL scan_wr_ready cyc=%0d got=%b exp=%b", k, wr_if.wr_ready, (k % 20) != 19);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_atomic_update();
        logic [3:0] e;
        start();
        for (int k = 0; k < 40; k++) begin
            if (k == 5)       put_wr(3'd0, 4'h3);
            else if (k == 14) put_wr(3'd1, 4'hA);
            else              idle_wr();
            #1;
            if (k == 5 || k == 14) begin
                total++;
                if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL atomic_wr_ready cyc=%0d got=%b exp=1", k, wr_if.wr_ready); end
            end
            if (k < 20)      e = 4'h0;
            else if (k < 30) e = 4'h3;
            else             e = 4'hA;
            total++;
            if (nibble !== e) begin bad++; $display("FAIL atomic_nibble cyc=%0d got=%h exp=%h", k, nibble, e); end
            @(negedge clk);
        end
        idle_wr();
    endtask

    task automatic test_overwrite_range();
        logic [3:0] e;
        start();
        for (int k = 0; k < 40; k++) begin
            if (k == 3)      put_wr(3'd0, 4'h1);
            else if (k == 4) put_wr(3'd0, 4'h7);
            else if (k == 6) put_wr(3'd5, 4'hF);
            else             idle_wr();
            #1;
            if (k == 3 || k == 4 || k == 6) begin
                total++;
                if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL overwrite_wr_ready cyc=%0d got=%b exp=1", k, wr_if.wr_ready); end
            end
            if (k >= 20 && k < 30) e = 4'h7;
            else                   e = 4'h0;
            total++;
            if (nibble !== e) begin bad++; $display("FAIL overwrite_nibble cyc=%0d got=%h exp=%h", k, nibble, e); end
            @(negedge clk);
        end
        idle_wr();
    endtask

    task automatic test_commit_collision();
        logic [3:0] e;
        start();
        for (int k = 0; k < 60; k++) begin
            if (k == 5)                 put_wr(3'd1, 4'hC);
            else if (k == 19 || k == 20) put_wr(3'd1, 4'h5);
            else                        idle_wr();
            #1;
            if (k == 19) begin
                total++;
                if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL collision_ready_commit got=%b exp=0", wr_if.wr_ready); end
            end
            if (k == 20) begin
                total++;
                if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL collision_ready_after got=%b exp=1", wr_if.wr_ready); end
            end
            if (k >= 30 && k < 40)      e = 4'hC;
            else if (k >= 50)           e = 4'h5;
            else                        e = 4'h0;
            total++;
            if (nibble !== e) begin bad++; $display("FAIL collision_nibble cyc=%0d got=%h exp=%h", k, nibble, e); end
            @(negedge clk);
        end
        idle_wr();
    endtask

    task automatic test_mid_reset();
        start();
        for (int k = 0; k < 15; k++) begin
            if (k == 8) put_wr(3'd0, 4'h9);
            else        idle_wr();
            @(negedge clk);
        end
        idle_wr();
        reset = 1'b0;
        #1;
        total++;
        if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL midreset_wr_ready got=%b exp=0", wr_if.wr_ready); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            #1;
            total++;
            if (digit_en !== exp_en(k)) begin
                bad++; $display("FAIL midreset_digit_en cyc=%0d got=%b exp=%b", k, digit_en, exp_en(k));
            end
            total++;
            if (nibble !== 4'h0) begin bad++; $display("FAIL midreset_nibble cyc=%0d got=%h exp=0", k, nibble); end
            total++;
            if (frame_tick !== ((k % 20) == 19)) begin
                bad++; $display("FAIL midreset_frame_tick cyc=%0d got=%b exp=%b", k, frame_tick, (k % 20) == 19);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        start();
        for (int k = 0; k < 60; k++) begin
            if (k == 2)       put_wr(3'd0, 4'h4);
            else if (k == 3)  put_wr(3'd1, 4'h6);
            else if (k == 25) put_wr(3'd0, 4'h8);
            else if (k == 26) put_wr(3'd1, 4'h2);
            else              idle_wr();
            #1;
            if (k < 20)      e = 4'h0;
            else if (k < 30) e = 4'h4;
            else if (k < 40) e = 4'h6;
            else if (k < 50) e = 4'h8;
            else             e = 4'h2;
            total++;
            if (nibble !== e) begin bad++; $display("FAIL b2b_nibble cyc=%0d got=%h exp=%h", k, nibble, e); end
            @(negedge clk);
        end
        idle_wr();
    endtask

`ifdef BRIGHTNESS_PWM_EN
    task automatic test_brightness();
        logic [1:0] e;
        brightness = 4'd3;
        start();
        for (int k = 0; k < 40; k++) begin
            #1;
            e = ((k % 16) <= 3) ? exp_en(k) : 2'b00;
            total++;
            if (digit_en !== e) begin bad++; $display("FAIL pwm3_digit_en cyc=%0d got=%b exp=%b", k, digit_en, e); end
            @(negedge clk);
        end
        brightness = 4'd15;
        start();
        for (int k = 0; k < 40; k++) begin
            #1;
            total++;
            if (digit_en !== exp_en(k)) begin bad++; $display("FAIL pwm15_digit_en cyc=%0d got=%b exp=%b", k, digit_en, exp_en(k)); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        idle_wr();
        test_reset();
        test_atomic_update();
        test_overwrite_range();
        test_commit_collision();
        test_mid_reset();
        test_back_to_back();
`ifdef BRIGHTNESS_PWM_EN
        test_brightness();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
